// File: rtl/axis_xbar_rr.sv
// AXI-Stream crossbar: each destination runs its own round-robin arbiter that locks a
// source for a whole packet and feeds a single registered output slice.
module axis_xbar_rr #(
    parameter int T_DATA_WIDTH = 8,
    parameter int S_DATA_COUNT = 5,
    parameter int M_DATA_COUNT = 3,
    parameter int T_ID___WIDTH = (S_DATA_COUNT > 1) ? $clog2(S_DATA_COUNT) : 1,
    parameter int T_DEST_WIDTH = (M_DATA_COUNT > 1) ? $clog2(M_DATA_COUNT) : 1
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [S_DATA_COUNT-1:0]              s_valid_i,
    output logic [S_DATA_COUNT-1:0]              s_ready_o,
    input  logic [T_DATA_WIDTH*S_DATA_COUNT-1:0] s_data_i,
    input  logic [S_DATA_COUNT-1:0]              s_last_i,
    input  logic [T_DEST_WIDTH*S_DATA_COUNT-1:0] s_dest_i,
    output logic [M_DATA_COUNT-1:0]              m_valid_o,
    input  logic [M_DATA_COUNT-1:0]              m_ready_i,
    output logic [T_DATA_WIDTH*M_DATA_COUNT-1:0] m_data_o,
    output logic [M_DATA_COUNT-1:0]              m_last_o,
    output logic [T_ID___WIDTH*M_DATA_COUNT-1:0] m_id_o
);
    typedef enum logic {IDLE, BUSY} state_t;

    logic                                        r_rst_q;
    logic [S_DATA_COUNT-1:0][T_DATA_WIDTH-1:0]   w_sdata;
    logic [S_DATA_COUNT-1:0][T_DEST_WIDTH-1:0]   w_dest;
    logic [M_DATA_COUNT-1:0][T_DATA_WIDTH-1:0]   w_mdata;
    logic [M_DATA_COUNT-1:0][T_ID___WIDTH-1:0]   w_mid;
    logic [M_DATA_COUNT-1:0][T_ID___WIDTH-1:0]   w_gnt;
    logic [M_DATA_COUNT-1:0]                     w_busy;
    logic [M_DATA_COUNT-1:0]                     w_out_free;
    logic [M_DATA_COUNT-1:0]                     w_mvld;
    logic [M_DATA_COUNT-1:0]                     w_mlast;
    logic [S_DATA_COUNT-1:0]                     w_taken;
    logic [S_DATA_COUNT-1:0]                     w_ready;

    assign w_sdata   = s_data_i;
    assign w_dest    = s_dest_i;
    assign m_data_o  = w_mdata;
    assign m_id_o    = w_mid;
    assign m_valid_o = w_mvld;
    assign m_last_o  = w_mlast;
    assign s_ready_o = w_ready;

    always_ff @(posedge clk) begin
        r_rst_q <= rst;
    end

    // A locked source only sees its owner's slice; unroutable sources are sunk while unowned.
    always_comb begin
        w_taken = '0;
        w_ready = '0;
        for (int i = 0; i < M_DATA_COUNT; i++) begin
            if (w_busy[i]) begin
                w_taken[w_gnt[i]] = 1'b1;
                w_ready[w_gnt[i]] = w_out_free[i];
            end
        end
        for (int j = 0; j < S_DATA_COUNT; j++) begin
            if (!w_taken[j] && (int'(w_dest[j]) >= M_DATA_COUNT)) begin
                w_ready[j] = 1'b1;
            end
        end
        if (r_rst_q) begin
            w_ready = '0;
        end
    end

    for (genvar gi = 0; gi < M_DATA_COUNT; gi++) begin : g_dst
        state_t                  r_state;
        logic [T_ID___WIDTH-1:0] r_grant;
        logic [T_ID___WIDTH-1:0] r_ptr;
        logic                    r_vld_p1;
        logic [T_DATA_WIDTH-1:0] r_data_p1;
        logic                    r_last_p1;
        logic [T_ID___WIDTH-1:0] r_id_p1;
        logic [S_DATA_COUNT-1:0] w_req;
        logic                    w_any;
        logic [T_ID___WIDTH-1:0] w_pick;
        logic                    w_acc;

        assign w_busy[gi]     = (r_state == BUSY);
        assign w_gnt[gi]      = r_grant;
        assign w_out_free[gi] = ~r_vld_p1 | m_ready_i[gi];
        assign w_acc          = (r_state == BUSY) & s_valid_i[r_grant] & w_out_free[gi];
        assign w_mvld[gi]     = r_vld_p1;
        assign w_mlast[gi]    = r_last_p1;
        assign w_mdata[gi]    = r_data_p1;
        assign w_mid[gi]      = r_id_p1;

        always_comb begin
            for (int j = 0; j < S_DATA_COUNT; j++) begin
                w_req[j] = s_valid_i[j] & ~w_taken[j] & (int'(w_dest[j]) == gi);
            end
        end

        always_comb begin
            int idx;
            idx    = 0;
            w_any  = 1'b0;
            w_pick = '0;
            for (int k = 0; k < S_DATA_COUNT; k++) begin
                idx = int'(r_ptr) + k;
                if (idx >= S_DATA_COUNT) idx -= S_DATA_COUNT;
                if (!w_any && w_req[idx[T_ID___WIDTH-1:0]]) begin
                    w_any  = 1'b1;
                    w_pick = idx[T_ID___WIDTH-1:0];
                end
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                r_state   <= IDLE;
                r_grant   <= '0;
                r_ptr     <= '0;
                r_vld_p1  <= 1'b0;
                r_data_p1 <= '0;
                r_last_p1 <= 1'b0;
                r_id_p1   <= '0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (w_any) begin
                            r_grant <= w_pick;
                            r_state <= BUSY;
                        end
                    end
                    BUSY: begin
                        if (w_acc && s_last_i[r_grant]) begin
                            r_state <= IDLE;
                            r_ptr   <= (int'(r_grant) == S_DATA_COUNT - 1) ? '0 : r_grant + 1'b1;
                        end
                    end
                    default: r_state <= IDLE;
                endcase
                // p1: output slice, loaded on acceptance, held under backpressure
                if (w_acc) begin
                    r_vld_p1  <= 1'b1;
                    r_data_p1 <= w_sdata[r_grant];
                    r_last_p1 <= s_last_i[r_grant];
                    r_id_p1   <= r_grant;
                end else if (m_ready_i[gi]) begin
                    r_vld_p1  <= 1'b0;
                end
            end
        end
    end
endmodule
